// File: rtl/fpu_pkg.sv
// Shared single-precision types and helpers for the FPU pipelines.
// The float layout is the IEEE-754 binary32 bit order.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    // Special-case flags computed once at the divider input
    typedef struct packed {
        logic z1;
        logic z2;
        logic inf2;
    } div_flags_t;

    typedef enum logic [1:0] {
        FC_NORM = 2'd0,
        FC_INF  = 2'd1,
        FC_ZERO = 2'd2
    } fclass_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        fclass_t    cls;
        logic       unity;
    } finv_meta_t;

    function automatic logic is_zero_exp(input float_t f);
        return f.exp == 8'd0;
    endfunction

endpackage

// File: rtl/finv.sv
// Pipelined binary32 reciprocal, three register stages.
// Mantissa is a 24-bit restoring division of 2^47 by {1,man}, 8 quotient bits per stage.
module finv
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    output logic [31:0] y
);

    localparam int STEPS = 8;

    // Returns {remainder, quotient}; remainder stays below d except for the
    // unity mantissa, whose result is overridden downstream.
    function automatic logic [47:0] div_steps(input logic [23:0] rem_in,
                                              input logic [23:0] q_in,
                                              input logic [23:0] d);
        logic [24:0] r;
        logic [23:0] q;
        r = {1'b0, rem_in};
        q = q_in;
        for (int i = 0; i < STEPS; i++) begin
            r = {r[23:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r = r - {1'b0, d};
                q = {q[22:0], 1'b1};
            end else begin
                q = {q[22:0], 1'b0};
            end
        end
        return {r[23:0], q};
    endfunction

    float_t     fx;
    logic [8:0] e_t;
    finv_meta_t meta0;
    logic [23:0] d0;
    logic [47:0] step1, step2, step3;
    logic [23:0] q_rnd;
    logic [31:0] y_d;

    logic [23:0] s1_d, s1_rem, s1_q;
    logic [23:0] s2_d, s2_rem, s2_q;
    finv_meta_t  s1_meta, s2_meta;

    assign fx = float_t'(x);
    assign d0 = {1'b1, fx.man};
    // 1/m lands in (0.5,1) unless m==1, hence the extra -1 on the exponent
    assign e_t = ((fx.man == 23'd0) ? 9'd254 : 9'd253) - {1'b0, fx.exp};

    always_comb begin
        meta0       = '0;
        meta0.sign  = fx.sign;
        meta0.exp   = e_t[7:0];
        meta0.unity = (fx.man == 23'd0);
        if (is_zero_exp(fx))
            meta0.cls = FC_INF;
        else if (fx.exp == 8'hFF || e_t[8])
            meta0.cls = FC_ZERO;
        else
            meta0.cls = FC_NORM;
    end

    assign step1 = div_steps(24'h800000, 24'd0, d0);
    assign step2 = div_steps(s1_rem, s1_q, s1_d);
    assign step3 = div_steps(s2_rem, s2_q, s2_d);

    // Final remainder decides round-to-nearest; cannot carry out for m>1
    assign q_rnd = step3[23:0] + {23'd0, ({step3[47:24], 1'b0} >= {1'b0, s2_d})};

    always_comb begin
        y_d = {s2_meta.sign, s2_meta.exp, q_rnd[22:0]};
        case (s2_meta.cls)
            FC_INF:  y_d = {s2_meta.sign, 8'hFF, 23'd0};
            FC_ZERO: y_d = {s2_meta.sign, 31'd0};
            default: if (s2_meta.unity) y_d = {s2_meta.sign, s2_meta.exp, 23'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_d    <= '0;
            s1_rem  <= '0;
            s1_q    <= '0;
            s1_meta <= '0;
            s2_d    <= '0;
            s2_rem  <= '0;
            s2_q    <= '0;
            s2_meta <= '0;
            y       <= '0;
        end else begin
            s1_d    <= d0;
            s1_rem  <= step1[47:24];
            s1_q    <= step1[23:0];
            s1_meta <= meta0;
            s2_d    <= s1_d;
            s2_rem  <= step2[47:24];
            s2_q    <= step2[23:0];
            s2_meta <= s1_meta;
            y       <= y_d;
        end
    end

endmodule

// File: rtl/fmul_core.sv
// Two-stage binary32 multiply (A: mantissa product and exponent sum,
// B: normalise, round-nearest-even, specials). Result sign is a.sign ^ b.sign.
module fmul_core
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  flags,
    output logic [31:0] y
);

    localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);
    localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);

    float_t fa, fb;
    assign fa = float_t'(a);
    assign fb = float_t'(b);

    logic [47:0]       prod_q;
    logic signed [9:0] esum_q;
    logic              sign_q;
    div_flags_t        flg_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q <= '0;
            esum_q <= '0;
            sign_q <= 1'b0;
            flg_q  <= '0;
        end else begin
            prod_q <= {24'd0, 1'b1, fa.man} * {24'd0, 1'b1, fb.man};
            esum_q <= $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - E_BIAS;
            sign_q <= fa.sign ^ fb.sign;
            flg_q  <= div_flags_t'(flags);
        end
    end

    logic [23:0]       keep;
    logic              guard, sticky;
    logic [24:0]       rnd;
    logic [22:0]       man;
    logic signed [9:0] e1, e2;
    logic [31:0]       y_d;

    always_comb begin
        keep   = prod_q[47] ? prod_q[47:24] : prod_q[46:23];
        guard  = prod_q[47] ? prod_q[23] : prod_q[22];
        sticky = prod_q[47] ? (|prod_q[22:0]) : (|prod_q[21:0]);
        e1     = esum_q + (prod_q[47] ? 10'sd1 : 10'sd0);
        rnd    = {1'b0, keep} + {24'd0, guard & (sticky | keep[0])};
        // Carry out only from all-ones, so the renormalised mantissa is zero
        man    = rnd[24] ? rnd[23:1] : rnd[22:0];
        e2     = e1 + (rnd[24] ? 10'sd1 : 10'sd0);

        y_d = {sign_q, e2[7:0], man};
        if (flg_q.z2)
            y_d = {sign_q, 8'hFF, 23'd0};
        else if (flg_q.z1 || flg_q.inf2)
            y_d = {sign_q, 31'd0};
        else if (e2 >= E_MAX)
            y_d = {sign_q, 8'hFF, 23'd0};
        else if (e2 <= 10'sd0)
            y_d = {sign_q, 31'd0};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) y <= '0;
        else       y <= y_d;
    end

endmodule

// File: rtl/fdiv_pipe.sv
// Pipelined binary32 divider y = x1 * finv(x2), one operand pair per cycle.
// x1 and the special flags ride a FINV_LAT-deep delay line to meet finv's result.
module fdiv_pipe
    import fpu_pkg::*;
#(
    parameter int FINV_LAT = 3,
    parameter int FMUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    output logic [31:0] y
);

    localparam int LAT = FINV_LAT + FMUL_LAT;

    div_flags_t                flags_in;
    logic [FINV_LAT-1:0][31:0] x1_dly;
    div_flags_t [FINV_LAT-1:0] flg_dly;
    logic [LAT-1:0]            vld_pipe;
    logic [31:0]               r;

    assign flags_in = '{z1:   is_zero_exp(float_t'(x1)),
                        z2:   is_zero_exp(float_t'(x2)),
                        inf2: (x2[30:23] == 8'hFF)};

    finv u_finv (
        .clk  (clk),
        .rstn (rstn),
        .x    (x2),
        .y    (r)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x1_dly   <= '0;
            flg_dly  <= '0;
            vld_pipe <= '0;
        end else begin
            x1_dly[0]  <= x1;
            flg_dly[0] <= flags_in;
            for (int i = 1; i < FINV_LAT; i++) begin
                x1_dly[i]  <= x1_dly[i-1];
                flg_dly[i] <= flg_dly[i-1];
            end
            vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
        end
    end

    fmul_core u_fmul (
        .clk   (clk),
        .rstn  (rstn),
        .a     (x1_dly[FINV_LAT-1]),
        .b     (r),
        .flags (flg_dly[FINV_LAT-1]),
        .y     (y)
    );

    assign out_valid = vld_pipe[LAT-1];

endmodule

// File: tb/tb_fdiv_pipe.sv
// Self-checking bench for fdiv_pipe: real-arithmetic reference model with
// ulp tolerance, per-cycle valid/data compare, plus directed literal vectors.
`timescale 1ns/1ps
module tb_fdiv_pipe;

    localparam int FINV_LAT = 3;
    localparam int FMUL_LAT = 2;
    localparam int L        = FINV_LAT + FMUL_LAT;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        out_valid;
    logic [31:0] y;

    int n_vec = 0;
    int n_err = 0;

    fdiv_pipe #(.FINV_LAT(FINV_LAT), .FMUL_LAT(FMUL_LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .y         (y)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Expected quotient from the divide rules; tol is the allowed ulp distance
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output int tol);
        logic        s;
        real         q;
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        s   = a[31] ^ b[31];
        tol = 0;
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'hFF) return {s, 31'd0};
        q = f2r(a) / f2r(b);
        d = $realtobits(q);
        e = int'(d[62:52]) - 1023 + 127;
        m = {1'b0, d[51:29]} + {23'd0, d[28]};
        if (m[23]) e++;
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        tol = 4;
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic int ulp_diff(input logic [31:0] a, input logic [31:0] b);
        int dd;
        dd = int'({1'b0, a[30:0]}) - int'({1'b0, b[30:0]});
        return (dd < 0) ? -dd : dd;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want, input int tol);
        n_vec++;
        if ($isunknown(act) || act[31] !== want[31] || ulp_diff(act, want) > tol) begin
            n_err++;
            $display("FAIL %s: y=%h, expected %h within %0d ulp (ulp diff %0d)",
                     name, act, want, tol, ulp_diff(act, want));
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, want);
        end
    endtask

    // Input history, one entry per rising edge; entries before a reset are discarded
    bit          hv  [0:4095];
    logic [31:0] hx1 [0:4095];
    logic [31:0] hx2 [0:4095];
    int          cyc = 0;
    int          flush_upto = 0;

    initial forever begin
        @(posedge clk);
        hv[cyc]  = rstn && in_valid;
        hx1[cyc] = x1;
        hx2[cyc] = x2;
        cyc++;
    end

    initial forever begin
        @(negedge rstn);
        flush_upto = cyc;
    end

    initial begin
        int          src;
        bit          ev;
        int          tol;
        logic [31:0] want;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check_bit("reset out_valid", out_valid, 1'b0);
                check("reset y", y, 32'h0, 0);
            end else begin
                src = cyc - L;
                ev  = (src >= 0) && (src >= flush_upto) && hv[src];
                check_bit("out_valid pattern", out_valid, ev);
                if (ev && out_valid) begin
                    want = ref_div(hx1[src], hx2[src], tol);
                    check($sformatf("y for %h/%h", hx1[src], hx2[src]), y, want, tol);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        in_valid = v;
        x1 = a;
        x2 = b;
    endtask

    // Single pulse, then pin the exact latency and the literal result
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want, input int tol);
        drive(1'b1, a, b);
        drive(1'b0, $urandom, $urandom);
        repeat (L - 2) @(posedge clk);
        #1;
        check_bit({name, " early valid"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_bit({name, " valid at L"}, out_valid, 1'b1);
        check(name, y, want, tol);
        $display("%s: y=%h ulp diff %0d", name, y, ulp_diff(y, want));
    endtask

    function automatic logic [31:0] rand_norm();
        return {1'($urandom), 8'($urandom_range(175, 80)), 23'($urandom)};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_bit("initial reset out_valid", out_valid, 1'b0);
        check("initial reset y", y, 32'h0, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        directed("3/2",        32'h40400000, 32'h40000000, 32'h3FC00000, 4);
        directed("-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000, 0);
        directed("0/3",        32'h00000000, 32'h40400000, 32'h00000000, 0);
        directed("overflow",   32'h7F000000, 32'h00800000, 32'h7F800000, 0);
        directed("underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 0);
        directed("-5/3",       32'hC0A00000, 32'h40400000, 32'hBFD55555, 4);

        for (int i = 0; i < 50; i++) drive(1'b1, rand_norm(), rand_norm());
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_norm(), rand_norm());
            repeat ($urandom_range(3, 0)) drive(1'b0, $urandom, $urandom);
        end
        repeat (L + 2) drive(1'b0, $urandom, $urandom);

        // Reset with three pairs in flight
        for (int i = 0; i < 3; i++) drive(1'b1, rand_norm(), rand_norm());
        #3;
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        check_bit("mid-flight reset out_valid", out_valid, 1'b0);
        check("mid-flight reset y", y, 32'h0, 0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (L + 2) drive(1'b0, $urandom, $urandom);
        directed("3/2 after reset", 32'h40400000, 32'h40000000, 32'h3FC00000, 4);
        repeat (3) drive(1'b0, $urandom, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
